// File: rtl/cache_coherence_array.sv
// cache_coherence_array
//   MESI-style state holder for NUM_LINES = 2**IDX_W cache sectors. One CPU
//   transaction is served at a time by a shared transaction FSM
//   (IDLE / FILL / WAIT_INV / WRITEBACK). The bus is snooped every cycle
//   against the per-line state array.
//
// Optional feature macro: TMO_WATCHDOG_EN
//   When defined, a TMO_W-bit watchdog aborts any non-IDLE state that stalls.
//   When defined, it also adds the timeout_err output.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cpu_req_*           CPU request channel (valid/ready), index and op
//   cpu_resp_valid      one-cycle completion pulse, cpu_resp_abort qualifies it
//   snoop_*             bus snoop: valid, line index, write(1)/read(0)
//   read_done, send_abort, all_inv_done, write_back_done   bus/memory events
//   cache_sector_fill, invalidate, adr_retry   registered one-cycle pulses
//   busy                transaction FSM not IDLE
//   query_idx/state     combinational debug read of one line state
//   timeout_err         (TMO_WATCHDOG_EN only) watchdog expiry pulse
//
// Handshake: a request transfers on a cycle where cpu_req_valid && cpu_req_ready.
// Ready is high only when the FSM is IDLE and no snoop is present, so a snoop
// always wins over a new request. Responses are not back-pressured.
module cache_coherence_array #(
  parameter int IDX_W = 3,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req_valid,
  output logic             cpu_req_ready,
  input  logic [IDX_W-1:0] cpu_req_idx,
  input  logic [1:0]       cpu_req_op,
  output logic             cpu_resp_valid,
  output logic             cpu_resp_abort,
  input  logic             snoop_valid,
  input  logic [IDX_W-1:0] snoop_idx,
  input  logic             snoop_wr,
  input  logic             read_done,
  input  logic             send_abort,
  input  logic             all_inv_done,
  input  logic             write_back_done,
  output logic             cache_sector_fill,
  output logic             invalidate,
  output logic             adr_retry,
  output logic             busy,
  input  logic [IDX_W-1:0] query_idx,
  output logic [1:0]       query_state
`ifdef TMO_WATCHDOG_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int NUM_LINES = 1 << IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] FSM_IDLE      = 2'd0;
  localparam logic [1:0] FSM_FILL      = 2'd1;
  localparam logic [1:0] FSM_WAIT_INV  = 2'd2;
  localparam logic [1:0] FSM_WRITEBACK = 2'd3;

  localparam logic [1:0] OP_RS = 2'b00;
  localparam logic [1:0] OP_RX = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  logic [1:0]       line_q [NUM_LINES];
  logic [1:0]       line_d [NUM_LINES];
  logic [1:0]       fsm_q, fsm_d;
  logic [IDX_W-1:0] act_idx_q, act_idx_d;
  logic [1:0]       act_op_q, act_op_d;
  logic             resp_d, abort_d, fill_d, inv_d, retry_d;
  logic [1:0]       req_op;
  logic [1:0]       req_line;

`ifdef TMO_WATCHDOG_EN
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_d;
`else
  logic [31:0]      unused_tmo_w;
  assign unused_tmo_w = TMO_W;
`endif

  assign busy          = (fsm_q != FSM_IDLE);
  assign cpu_req_ready = (fsm_q == FSM_IDLE) && !snoop_valid;
  assign query_state   = line_q[query_idx];

  // Reserved op 11 behaves as read-shared.
  assign req_op   = (cpu_req_op == 2'b11) ? OP_RS : cpu_req_op;
  assign req_line = line_q[cpu_req_idx];

  always_comb begin
    line_d    = line_q;
    fsm_d     = fsm_q;
    act_idx_d = act_idx_q;
    act_op_d  = act_op_q;
    resp_d    = 1'b0;
    abort_d   = 1'b0;
    fill_d    = 1'b0;
    inv_d     = 1'b0;
    retry_d   = 1'b0;
`ifdef TMO_WATCHDOG_EN
    tmo_d     = 1'b0;
`endif

    // Transaction FSM. It only ever touches act_idx (or the accepted index
    // in IDLE, which cannot coincide with a snoop because ready is low then).
    case (fsm_q)
      FSM_IDLE: begin
        if (cpu_req_valid && cpu_req_ready) begin
          act_idx_d = cpu_req_idx;
          act_op_d  = req_op;
          if (req_line == ST_I) begin
            fill_d = 1'b1;
            fsm_d  = FSM_FILL;
          end else if (req_op != OP_WR) begin
            resp_d = 1'b1;
          end else if (req_line == ST_S) begin
            inv_d = 1'b1;
            fsm_d = FSM_WAIT_INV;
          end else begin
            line_d[cpu_req_idx] = ST_M;
            resp_d              = 1'b1;
          end
        end
      end
      FSM_FILL: begin
        if (send_abort) begin
          line_d[act_idx_q] = ST_I;
          resp_d            = 1'b1;
          abort_d           = 1'b1;
          fsm_d             = FSM_IDLE;
        end else if (read_done) begin
          if (act_op_q == OP_WR) begin
            inv_d = 1'b1;
            fsm_d = FSM_WAIT_INV;
          end else begin
            line_d[act_idx_q] = (act_op_q == OP_RX) ? ST_E : ST_S;
            resp_d            = 1'b1;
            fsm_d             = FSM_IDLE;
          end
        end
      end
      FSM_WAIT_INV: begin
        if (all_inv_done) begin
          line_d[act_idx_q] = ST_M;
          resp_d            = 1'b1;
          fsm_d             = FSM_IDLE;
        end
      end
      default: begin // FSM_WRITEBACK
        if (write_back_done) begin
          line_d[act_idx_q] = ST_S;
          fsm_d             = FSM_IDLE;
        end
      end
    endcase

`ifdef TMO_WATCHDOG_EN
    // A real completion in the same cycle as expiry wins.
    if (fsm_q != FSM_IDLE && fsm_d == fsm_q && tmo_cnt_q == {TMO_W{1'b1}}) begin
      line_d[act_idx_q] = ST_I;
      fsm_d             = FSM_IDLE;
      tmo_d             = 1'b1;
      if (fsm_q != FSM_WRITEBACK) begin
        resp_d  = 1'b1;
        abort_d = 1'b1;
      end
    end
`endif

    // Snooper. When busy it never modifies act_idx, so it cannot collide with
    // the FSM update above.
    if (snoop_valid) begin
      if (busy && snoop_idx == act_idx_q) begin
        retry_d = 1'b1;
      end else if (snoop_wr) begin
        line_d[snoop_idx] = ST_I;
      end else if (line_q[snoop_idx] == ST_E) begin
        line_d[snoop_idx] = ST_S;
      end else if (line_q[snoop_idx] == ST_M) begin
        retry_d = 1'b1;
        if (fsm_q == FSM_IDLE) begin
          fsm_d     = FSM_WRITEBACK;
          act_idx_d = snoop_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) line_q[i] <= ST_I;
      fsm_q             <= FSM_IDLE;
      act_idx_q         <= '0;
      act_op_q          <= OP_RS;
      cpu_resp_valid    <= 1'b0;
      cpu_resp_abort    <= 1'b0;
      cache_sector_fill <= 1'b0;
      invalidate        <= 1'b0;
      adr_retry         <= 1'b0;
    end else begin
      line_q            <= line_d;
      fsm_q             <= fsm_d;
      act_idx_q         <= act_idx_d;
      act_op_q          <= act_op_d;
      cpu_resp_valid    <= resp_d;
      cpu_resp_abort    <= abort_d;
      cache_sector_fill <= fill_d;
      invalidate        <= inv_d;
      adr_retry         <= retry_d;
    end
  end

`ifdef TMO_WATCHDOG_EN
  // Counts cycles spent in the current non-IDLE state; any state change clears it.
  always_ff @(posedge clk) begin
    if (reset || fsm_d != fsm_q) tmo_cnt_q <= '0;
    else if (fsm_q != FSM_IDLE)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
    if (reset) timeout_err <= 1'b0;
    else       timeout_err <= tmo_d;
  end
`endif

endmodule

// File: tb/tb_cache_coherence_array.sv
module tb_cache_coherence_array;

  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_req_valid;
  logic             cpu_req_ready;
  logic [IDX_W-1:0] cpu_req_idx;
  logic [1:0]       cpu_req_op;
  logic             cpu_resp_valid;
  logic             cpu_resp_abort;
  logic             snoop_valid;
  logic [IDX_W-1:0] snoop_idx;
  logic             snoop_wr;
  logic             read_done;
  logic             send_abort;
  logic             all_inv_done;
  logic             write_back_done;
  logic             cache_sector_fill;
  logic             invalidate;
  logic             adr_retry;
  logic             busy;
  logic [IDX_W-1:0] query_idx;
  logic [1:0]       query_state;
`ifdef TMO_WATCHDOG_EN
  logic             timeout_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Expected abort flag of each CPU response, in order.
  logic [0:0] exp_q[$];

  cache_coherence_array #(.IDX_W(IDX_W), .TMO_W(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_req_valid     (cpu_req_valid),
    .cpu_req_ready     (cpu_req_ready),
    .cpu_req_idx       (cpu_req_idx),
    .cpu_req_op        (cpu_req_op),
    .cpu_resp_valid    (cpu_resp_valid),
    .cpu_resp_abort    (cpu_resp_abort),
    .snoop_valid       (snoop_valid),
    .snoop_idx         (snoop_idx),
    .snoop_wr          (snoop_wr),
    .read_done         (read_done),
    .send_abort        (send_abort),
    .all_inv_done      (all_inv_done),
    .write_back_done   (write_back_done),
    .cache_sector_fill (cache_sector_fill),
    .invalidate        (invalidate),
    .adr_retry         (adr_retry),
    .busy              (busy),
    .query_idx         (query_idx),
    .query_state       (query_state)
`ifdef TMO_WATCHDOG_EN
    ,
    .timeout_err       (timeout_err)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response scoreboard: every cpu_resp_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!reset && cpu_resp_valid) begin
      if (exp_q.size() == 0) check_eq("resp_unexpected", 32'd1, 32'd0);
      else check_eq("resp_abort", {31'd0, cpu_resp_abort}, {31'd0, exp_q.pop_front()});
    end
  end

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic query(input int idx, input logic [1:0] exp, input string tag);
    query_idx = idx[IDX_W-1:0];
    #1;
    check_eq(tag, {30'd0, query_state}, {30'd0, exp});
  endtask

  task automatic request(input int idx, input logic [1:0] op);
    cpu_req_valid = 1'b1;
    cpu_req_idx   = idx[IDX_W-1:0];
    cpu_req_op    = op;
    step();
    cpu_req_valid = 1'b0;
  endtask

  task automatic snoop(input int idx, input logic wr);
    snoop_valid = 1'b1;
    snoop_idx   = idx[IDX_W-1:0];
    snoop_wr    = wr;
    step();
    snoop_valid = 1'b0;
  endtask

  // Miss on a read op followed by a clean fill completion.
  task automatic fill_read(input int idx, input logic [1:0] op, input logic [1:0] exp_state, input string tag);
    request(idx, op);
    check_eq({tag, "_fill"}, {31'd0, cache_sector_fill}, 32'd1);
    exp_q.push_back(1'b0);
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    query(idx, exp_state, {tag, "_state"});
  endtask

  initial begin
    reset = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_idx = '0; cpu_req_op = 2'b00;
    snoop_valid = 1'b0; snoop_idx = '0; snoop_wr = 1'b0;
    read_done = 1'b0; send_abort = 1'b0; all_inv_done = 1'b0; write_back_done = 1'b0;
    query_idx = '0;
    step(); step();
    reset = 1'b0;

    // Reset values
    check_eq("rst_ready", {31'd0, cpu_req_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_pulses", {28'd0, cpu_resp_valid, cache_sector_fill, invalidate, adr_retry}, 32'd0);
    for (int i = 0; i < 8; i++) query(i, 2'b00, "rst_line");

    // Read-exclusive miss on 2, read_done three cycles later -> E
    request(2, 2'b01);
    check_eq("rx2_fill", {31'd0, cache_sector_fill}, 32'd1);
    check_eq("rx2_busy", {31'd0, busy}, 32'd1);
    check_eq("rx2_ready", {31'd0, cpu_req_ready}, 32'd0);
    step();
    check_eq("rx2_fill_once", {31'd0, cache_sector_fill}, 32'd0);
    step();
    exp_q.push_back(1'b0);
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check_eq("rx2_resp", {31'd0, cpu_resp_valid}, 32'd1);
    query(2, 2'b10, "rx2_state");

    // Line 5 to S, then write -> invalidate, WAIT_INV, all_inv_done -> M
    fill_read(5, 2'b00, 2'b01, "rs5");
    request(5, 2'b10);
    check_eq("wr5_inv", {31'd0, invalidate}, 32'd1);
    check_eq("wr5_busy", {31'd0, busy}, 32'd1);
    step();
    exp_q.push_back(1'b0);
    all_inv_done = 1'b1;
    step();
    all_inv_done = 1'b0;
    query(5, 2'b11, "wr5_state");

    // Write miss on 3: fill, then invalidate, then M
    request(3, 2'b10);
    check_eq("wr3_fill", {31'd0, cache_sector_fill}, 32'd1);
    read_done = 1'b1;
    step();
    read_done = 1'b0;
    check_eq("wr3_inv", {31'd0, invalidate}, 32'd1);
    check_eq("wr3_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(1'b0);
    all_inv_done = 1'b1;
    step();
    all_inv_done = 1'b0;
    query(3, 2'b11, "wr3_state");

    // Snoop read on M while IDLE -> retry, WRITEBACK, then S with no response
    snoop_valid = 1'b1; snoop_idx = 3'd3; snoop_wr = 1'b0;
    #1;
    check_eq("snp_ready_low", {31'd0, cpu_req_ready}, 32'd0);
    step();
    snoop_valid = 1'b0;
    check_eq("wb3_retry", {31'd0, adr_retry}, 32'd1);
    check_eq("wb3_busy", {31'd0, busy}, 32'd1);
    step();
    check_eq("wb3_retry_once", {31'd0, adr_retry}, 32'd0);
    write_back_done = 1'b1;
    step();
    write_back_done = 1'b0;
    check_eq("wb3_idle", {31'd0, busy}, 32'd0);
    query(3, 2'b01, "wb3_state");

    // send_abort and read_done together resolve to abort
    request(1, 2'b00);
    exp_q.push_back(1'b1);
    send_abort = 1'b1; read_done = 1'b1;
    step();
    send_abort = 1'b0; read_done = 1'b0;
    check_eq("ab1_resp", {30'd0, cpu_resp_valid, cpu_resp_abort}, 32'd3);
    query(1, 2'b00, "ab1_state");

    // Snoops during a fill on 4
    fill_read(6, 2'b01, 2'b10, "rx6");
    request(4, 2'b00);
    snoop(4, 1'b1);
    check_eq("f4_retry", {31'd0, adr_retry}, 32'd1);
    query(4, 2'b00, "f4_state_hold");
    snoop(5, 1'b0);
    check_eq("m5_retry", {31'd0, adr_retry}, 32'd1);
    check_eq("m5_busy", {31'd0, busy}, 32'd1);
    query(5, 2'b11, "m5_stays");
    snoop(6, 1'b1);
    check_eq("sw6_noretry", {31'd0, adr_retry}, 32'd0);
    query(6, 2'b00, "sw6_state");
    // fill completion and snoop write on another line in the same cycle
    exp_q.push_back(1'b0);
    read_done = 1'b1;
    snoop(2, 1'b1);
    read_done = 1'b0;
    query(4, 2'b01, "f4_done_state");
    query(2, 2'b00, "sw2_state");

    // Write hit on E -> M, read hit on M
    fill_read(7, 2'b01, 2'b10, "rx7");
    exp_q.push_back(1'b0);
    request(7, 2'b10);
    check_eq("we7_busy", {31'd0, busy}, 32'd0);
    check_eq("we7_resp", {31'd0, cpu_resp_valid}, 32'd1);
    query(7, 2'b11, "we7_state");
    exp_q.push_back(1'b0);
    request(7, 2'b00);
    check_eq("rh7_nofill", {31'd0, cache_sector_fill}, 32'd0);
    query(7, 2'b11, "rh7_state");

    // Reserved op behaves as read-shared
    fill_read(0, 2'b11, 2'b01, "op3");

    // Snoop read on E -> S, snoop write on S -> I
    fill_read(6, 2'b01, 2'b10, "rx6b");
    snoop(6, 1'b0);
    check_eq("sr6_noretry", {31'd0, adr_retry}, 32'd0);
    query(6, 2'b01, "sr6_state");
    snoop(6, 1'b1);
    query(6, 2'b00, "sw6b_state");

`ifdef TMO_WATCHDOG_EN
    begin
      logic seen;
      seen = 1'b0;
      request(0, 2'b10);
      check_eq("tmo_inv", {31'd0, invalidate}, 32'd1);
      exp_q.push_back(1'b1);
      for (int i = 0; i < 40; i++) begin
        step();
        if (timeout_err) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("tmo_seen", {31'd0, seen}, 32'd1);
      check_eq("tmo_idle", {31'd0, busy}, 32'd0);
      query(0, 2'b00, "tmo_state");
    end
`endif

    // Mid-transaction reset
    request(1, 2'b01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mrst_busy", {31'd0, busy}, 32'd0);
    query(7, 2'b00, "mrst_line");

    step(); step();
    check_eq("resp_missing", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
